rv4028_bus_responder: RTL

- Memory target on the RV4028 16-bit external bus: the responder end of the protocol the CPU core drives.
- Decodes a configurable address window and serves halfword reads from an internal RAM.
- Read wait states are inserted with wait_n; byte-masked writes are accepted.
- Used as on-board SRAM or scratch memory and as the bus-compliance model for CPU verification.

---
 rtl/rv4028_bus_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rv4028_bus_responder.sv
// RV4028 16-bit bus memory target: decodes an address window, serves halfword
// reads with programmable wait states and accepts byte-masked writes.
module rv4028_bus_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          IO_SPACE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [1:0]  wr_n,
    input  logic        rd_n,
    input  logic [1:0]  msk_n,
    input  logic [1:0]  mreq_n,
    input  logic        iorq_n,
    output logic        wait_n,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe
);
    localparam int unsigned IDX_W     = ADDR_BITS - 1;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, RWAIT, RDATA, WDATA} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      dout_q, dout_d;
    logic [15:0]      mem [DEPTH];

    logic             sel, wr_stb, win_hit, io_match;
    logic             rd_load, we_lo, we_hi;
    logic [IDX_W-1:0] addr_idx, rd_idx;
    logic             unused_bits;

    assign addr_idx    = addr[ADDR_BITS-1:1];
    assign win_hit     = (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign io_match    = IO_SPACE ? ~iorq_n : iorq_n;
    assign sel         = ~mreq_n[1] & win_hit & io_match;
    assign wr_stb      = ~&wr_n;
    assign unused_bits = ^{addr[0], mreq_n[0]};
    assign data_out    = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        wait_n  = 1'b1;
        data_oe = 1'b0;
        rd_load = 1'b0;
        rd_idx  = idx_q;
        we_lo   = 1'b0;
        we_hi   = 1'b0;
        case (state_q)
            IDLE: begin
                // A read in the same address phase as a write strobe wins.
                if (sel && !rd_n) begin
                    idx_d = addr_idx;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d = RDATA;
                        rd_load = 1'b1;
                        rd_idx  = addr_idx;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = RWAIT;
                    end
                end else if (sel && wr_stb) begin
                    idx_d   = addr_idx;
                    state_d = WDATA;
                end
            end
            RWAIT: begin
                wait_n = 1'b0;
                cnt_d  = cnt_q - 4'd1;
                if (rd_n || mreq_n[1]) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RDATA;
                    rd_load = 1'b1;
                end
            end
            RDATA: begin
                data_oe = 1'b1;
                state_d = IDLE;
            end
            WDATA: begin
                we_lo   = ~msk_n[0];
                we_hi   = ~msk_n[1];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rd_load) begin
            dout_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end

    // RAM is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem[idx_q][7:0] <= data_in[7:0];
        end
        if (we_hi) begin
            mem[idx_q][15:8] <= data_in[15:8];
        end
    end
endmodule
